// File: rtl/color_bands_gen.sv
`default_nettype none
// ============================================================================
//  Module      : color_bands_gen
//  Description : Colour-band test-pattern generator with a writable palette,
//                optional vertical scrolling and a 2-clock pixel pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module color_bands_gen #(
    parameter int COLOR_W   = 4,
    parameter int NUM_BANDS = 3,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   pixel_on,
    input  logic                   frame_start,
    input  logic [1:0]             mode,
    input  logic [3:0]             speed,
    input  logic                   pal_we,
    input  logic [3:0]             pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_data,
    output logic [COLOR_W-1:0]     red_out,
    output logic [COLOR_W-1:0]     green_out,
    output logic [COLOR_W-1:0]     blue_out,
    output logic                   pix_valid
);

    localparam int         c_pix_w       = 3 * COLOR_W;
    localparam int         c_band_h      = V_ACTIVE / NUM_BANDS;
    localparam int         c_band_w      = H_ACTIVE / NUM_BANDS;
    localparam logic [1:0] c_mode_h      = 2'd0;
    localparam logic [1:0] c_mode_v      = 2'd1;
    localparam logic [1:0] c_mode_scroll = 2'd2;
    localparam logic [1:0] c_mode_solid  = 2'd3;

    function automatic logic [c_pix_w-1:0] f_default(input int idx);
        logic [COLOR_W-1:0] m;
        logic [COLOR_W-1:0] z;
        m = '1;
        z = '0;
        case (idx % 3)
            0:       f_default = {z, m, z};
            1:       f_default = {m, m, z};
            default: f_default = {m, z, z};
        endcase
    endfunction

    logic [1:0]         r_mode;
    logic [9:0]         r_offset;
    logic [9:0]         r_s1_coord;
    logic               r_s1_vert;
    logic               r_s1_solid;
    logic               r_s1_on;
    logic [c_pix_w-1:0] r_pal [16];

    logic [10:0]        w_osum;
    logic [9:0]         w_offset_next;
    logic [10:0]        w_ysum;
    logic [9:0]         w_yeff;
    logic [9:0]         w_coord;
    logic [3:0]         w_idx;
    logic [c_pix_w-1:0] w_color;
    int                 w_coord_i;
    int                 w_band;
    int                 w_active;

    // Both sums stay below 2*V_ACTIVE, so one conditional subtract wraps them.
    assign w_osum        = {1'b0, r_offset} + {7'd0, speed};
    assign w_offset_next = (w_osum >= 11'(V_ACTIVE)) ? 10'(w_osum - 11'(V_ACTIVE)) : w_osum[9:0];
    assign w_ysum        = {1'b0, y} + {1'b0, r_offset};
    assign w_yeff        = (w_ysum >= 11'(V_ACTIVE)) ? 10'(w_ysum - 11'(V_ACTIVE)) : w_ysum[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= c_mode_h;
            r_offset <= '0;
        end else if (frame_start) begin
            r_mode <= mode;
            if (r_mode == c_mode_scroll)
                r_offset <= w_offset_next;
        end
    end

    always_comb begin
        w_coord = y;
        case (r_mode)
            c_mode_v:      w_coord = x;
            c_mode_scroll: w_coord = w_yeff;
            default:       w_coord = y;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_coord <= '0;
            r_s1_vert  <= 1'b0;
            r_s1_solid <= 1'b0;
            r_s1_on    <= 1'b0;
        end else begin
            r_s1_coord <= w_coord;
            r_s1_vert  <= (r_mode == c_mode_v);
            r_s1_solid <= (r_mode == c_mode_solid);
            r_s1_on    <= pixel_on;
        end
    end

    // Band index = number of band boundaries at or below the coordinate.
    always_comb begin
        w_coord_i = int'(r_s1_coord);
        w_band    = r_s1_vert ? c_band_w : c_band_h;
        w_active  = r_s1_vert ? H_ACTIVE : V_ACTIVE;
        w_idx     = 4'd0;
        for (int k = 1; k < NUM_BANDS; k++) begin
            if (w_coord_i >= k * w_band)
                w_idx = w_idx + 4'd1;
        end
        if (w_coord_i >= w_active)
            w_idx = 4'(NUM_BANDS - 1);
    end

    // Palette reads in the same edge as a write see the old entry.
    assign w_color = r_pal[r_s1_solid ? 4'd0 : w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                r_pal[i] <= f_default(i);
        end else if (pal_we && (int'(pal_addr) < NUM_BANDS)) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= r_s1_on;
            if (r_s1_on)
                {red_out, green_out, blue_out} <= w_color;
            else
                {red_out, green_out, blue_out} <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_bands_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_color_bands_gen
//  Description : Directed scoreboard bench for color_bands_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_color_bands_gen;

    logic        clk;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pixel_on;
    logic        frame_start;
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
    logic [3:0]  red_out;
    logic [3:0]  green_out;
    logic [3:0]  blue_out;
    logic        pix_valid;

    color_bands_gen #(
        .COLOR_W(4), .NUM_BANDS(3), .H_ACTIVE(640), .V_ACTIVE(480)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pixel_on(pixel_on),
        .frame_start(frame_start), .mode(mode), .speed(speed),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .pix_valid(pix_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [12:0] exp;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // Reference model state
    logic [1:0]  b_mode;
    int          b_offset;
    logic [11:0] b_pal [16];

    function automatic logic [12:0] model(input int xx, input int yy, input bit on);
        int c;
        int band;
        if (!on) return 13'd0;
        case (b_mode)
            2'd1:    begin c = xx;                      band = c / 213; end
            2'd2:    begin c = (yy + b_offset) % 480;   band = c / 160; end
            2'd3:    begin c = 0;                       band = 0;       end
            default: begin c = yy;                      band = c / 160; end
        endcase
        if (band > 2) band = 2;
        return {1'b1, b_pal[band]};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, {pix_valid, red_out, green_out, blue_out}, e.exp);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int xx, input int yy, input bit on, input string tag);
        exp_t e;
        e.due = cyc + 2;
        e.exp = model(xx, yy, on);
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic pix(input int xx, input int yy, input bit on, input string tag);
        step();
        x = 10'(xx); y = 10'(yy); pixel_on = on;
        push(xx, yy, on, tag);
    endtask

    task automatic pulse_fs();
        step();
        frame_start = 1'b1;
        pixel_on    = 1'b0;
        if (b_mode == 2'd2) b_offset = (b_offset + int'(speed)) % 480;
        b_mode = mode;
        step();
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            pixel_on = 1'b0;
        end
    endtask

    task automatic model_reset();
        b_mode   = 2'd0;
        b_offset = 0;
        for (int i = 0; i < 16; i++)
            b_pal[i] = (i % 3 == 0) ? 12'h0F0 : (i % 3 == 1) ? 12'hFF0 : 12'hF00;
    endtask

    initial begin
        rst_n = 1'b0; x = '0; y = '0; pixel_on = 1'b0; frame_start = 1'b0;
        mode = 2'd0; speed = 4'd0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        model_reset();
        #12;
        check("reset_state", {pix_valid, red_out, green_out, blue_out}, 13'd0);
        step();
        rst_n = 1'b1;
        idle(2);

        // Horizontal bands
        pix(0, 100, 1'b1, "m0_y100");
        pix(0, 160, 1'b1, "m0_y160");
        pix(0, 159, 1'b1, "m0_y159");
        pix(0, 479, 1'b1, "m0_y479");
        pix(0, 500, 1'b1, "m0_y500_clamp");
        pix(0, 479, 1'b0, "pixel_off");

        // Vertical bands, then a mid-frame mode change that must not apply yet
        mode = 2'd1;
        pulse_fs();
        pix(212, 300, 1'b1, "m1_x212");
        pix(213, 300, 1'b1, "m1_x213");
        pix(639, 300, 1'b1, "m1_x639");
        pix(700, 300, 1'b1, "m1_x700_clamp");
        mode = 2'd0;
        pix(213, 0, 1'b1, "m1_midframe_hold");

        // Scrolling
        mode = 2'd2; speed = 4'd0;
        pulse_fs();
        speed = 4'd5;
        pulse_fs();
        pulse_fs();
        pix(0, 150, 1'b1, "m2_off10_y150");
        pix(0, 149, 1'b1, "m2_off10_y149");
        for (int i = 0; i < 93; i++) pulse_fs();
        speed = 4'd3;
        pulse_fs();
        pix(0, 1, 1'b1, "m2_off478_y1");
        pix(0, 2, 1'b1, "m2_off478_y2_wrap");
        speed = 4'd5;
        pulse_fs();
        pix(0, 157, 1'b1, "m2_off3_y157");
        pix(0, 156, 1'b1, "m2_off3_y156");

        // Solid palette entry 0, then back to horizontal bands
        mode = 2'd3;
        pulse_fs();
        pix(0, 400, 1'b1, "m3_solid");
        mode = 2'd0;
        pulse_fs();
        pix(0, 400, 1'b1, "m0_after_solid");

        // Palette write colliding with a stage-2 read of the same entry
        pix(0, 200, 1'b1, "pal_prewrite");
        step();
        x = '0; y = 10'd200; pixel_on = 1'b1;
        pal_we = 1'b1; pal_addr = 4'd1; pal_data = 12'h0F0;
        b_pal[1] = 12'h0F0;
        push(0, 200, 1'b1, "pal_postwrite");
        step();
        pal_addr = 4'd5; pal_data = 12'hABC;
        pixel_on = 1'b0;
        step();
        pal_we = 1'b0;
        pix(0, 200, 1'b1, "pal_addr5_ignored");
        pix(0, 479, 1'b1, "pal_entry2_kept");
        idle(4);

        // Mid-frame asynchronous reset with pixels in flight
        mode = 2'd2; speed = 4'd0;
        pulse_fs();
        speed = 4'd7;
        pulse_fs();
        step();
        x = '0; y = 10'd200; pixel_on = 1'b1;
        step();
        step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", {pix_valid, red_out, green_out, blue_out}, 13'd0);
        model_reset();
        step();
        pixel_on = 1'b0;
        step();
        rst_n = 1'b1;
        mode  = 2'd2;
        pix(0, 200, 1'b0, "post_reset_flush");
        pix(0, 200, 1'b1, "post_reset_pal_default_mode0");
        speed = 4'd0;
        pulse_fs();
        pix(0, 150, 1'b1, "post_reset_offset0_y150");
        pix(0, 165, 1'b1, "post_reset_offset0_y165");
        idle(4);

        check("scoreboard_drained", 13'(q.size()), 13'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
